vga_timing_controller: RTL and testbench

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_sync_counter.sv | 73 +++++++
 rtl/vga_timing_controller.sv | 100 ++++++++++
 tb/tb_vga_timing_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, the transparent colour code and the RGB332 layout for the VGA controller.
// No logic: constants and one pure colour-expansion helper.
// No flow control; consumers are fixed-latency.
package vga_pkg;

    // 640x480 @ 60 Hz industry timing, one pixel per clock
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Counter width covers both totals (800 and 525 fit in 11 bits)
    localparam int CNT_W = 11;

    // Colour code treated as "transparent" and blanked to black
    localparam logic [7:0] MASK_VALUE_DEF = 8'h62;

    // RGB332 input layout and 4-bit-per-channel DAC output
    localparam int RGB332_W = 8;
    localparam int RGB_R_W  = 3;
    localparam int RGB_G_W  = 3;
    localparam int RGB_B_W  = 2;
    localparam int DAC_W    = 4;

    // Widen each channel to 4 bits by replicating its MSBs so full scale maps to 4'hF
    function automatic logic [3*DAC_W-1:0] rgb332_expand(input logic [RGB332_W-1:0] c);
        logic [RGB_R_W-1:0] r;
        logic [RGB_G_W-1:0] g;
        logic [RGB_B_W-1:0] b;
        r = c[7 -: RGB_R_W];
        g = c[4 -: RGB_G_W];
        b = c[1 -: RGB_B_W];
        return {r, r[RGB_R_W-1], g, g[RGB_G_W-1], b, b};
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters plus raw visible, sync and frame-start decode.
// Counters are registered; decode is combinational from the registered counters (same cycle).
// No backpressure: advances one pixel every clock.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             resetN,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             visible_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    // Raster advance: h every cycle, v on h wrap, both wrap at end of frame
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    // Counter registers; reset parks the raster at (0, 0)
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Raw decode for the current raster position; frame start marks the first blanking line
    always_comb begin
        visible_o     = (h_q < H_VIS) && (v_q < V_VIS);
        hsync_n_o     = !((h_q >= HS_START) && (h_q < HS_END));
        vsync_n_o     = !((v_q >= VS_START) && (v_q < VS_END));
        frame_start_o = (h_q == '0) && (v_q == V_VIS);
    end

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA timing generator: issues pixel requests, aligns returned colour with delayed syncs, masks and expands RGB332.
// Sync/visible outputs lag the request by PIPE_DELAY+1 cycles; colour is registered once to match.
// No backpressure: upstream must answer every request exactly PIPE_DELAY cycles later.
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int              H_ACTIVE   = H_ACTIVE_DEF,
    parameter int              H_FP       = H_FP_DEF,
    parameter int              H_SYNC     = H_SYNC_DEF,
    parameter int              H_BP       = H_BP_DEF,
    parameter int              V_ACTIVE   = V_ACTIVE_DEF,
    parameter int              V_FP       = V_FP_DEF,
    parameter int              V_SYNC     = V_SYNC_DEF,
    parameter int              V_BP       = V_BP_DEF,
    parameter int              PIPE_DELAY = 1,
    parameter logic [7:0]      MASK_VALUE = MASK_VALUE_DEF
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [RGB332_W-1:0] pixel_color_in,
    output logic [CNT_W-1:0]    requested_x,
    output logic [CNT_W-1:0]    requested_y,
    output logic                frame_start,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic [DAC_W-1:0]    vga_r,
    output logic [DAC_W-1:0]    vga_g,
    output logic [DAC_W-1:0]    vga_b,
    output logic                active_video
);

    logic raw_vis;
    logic raw_hs_n;
    logic raw_vs_n;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_cnt (
        .clk           (clk),
        .resetN        (resetN),
        .h_o           (requested_x),
        .v_o           (requested_y),
        .visible_o     (raw_vis),
        .hsync_n_o     (raw_hs_n),
        .vsync_n_o     (raw_vs_n),
        .frame_start_o (frame_start)
    );

    // Stage 0 is the newest; stage PIPE_DELAY lines up with the registered colour
    logic [PIPE_DELAY:0] vis_q,  vis_d;
    logic [PIPE_DELAY:0] hs_q,   hs_d;
    logic [PIPE_DELAY:0] vs_q,   vs_d;
    logic [RGB332_W-1:0] color_q;
    logic [3*DAC_W-1:0]  rgb;

    // Shift raw decode down the alignment pipeline
    always_comb begin
        vis_d = {vis_q[PIPE_DELAY-1:0], raw_vis};
        hs_d  = {hs_q[PIPE_DELAY-1:0],  raw_hs_n};
        vs_d  = {vs_q[PIPE_DELAY-1:0],  raw_vs_n};
    end

    // Pipeline and colour registers; reset forces blank, syncs inactive
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vis_q   <= '0;
            hs_q    <= '1;
            vs_q    <= '1;
            color_q <= '0;
        end else begin
            vis_q   <= vis_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            color_q <= pixel_color_in;
        end
    end

    // Blank outside the visible area and for the transparent code, else expand RGB332
    always_comb begin
        rgb = '0;
        if (vis_q[PIPE_DELAY] && (color_q != MASK_VALUE)) begin
            rgb = rgb332_expand(color_q);
        end
    end

    assign vga_r        = rgb[3*DAC_W-1 -: DAC_W];
    assign vga_g        = rgb[2*DAC_W-1 -: DAC_W];
    assign vga_b        = rgb[DAC_W-1   -: DAC_W];
    assign vga_hs       = hs_q[PIPE_DELAY];
    assign vga_vs       = vs_q[PIPE_DELAY];
    assign active_video = vis_q[PIPE_DELAY];

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench: a reduced-raster instance (25x11, PIPE_DELAY=1) for full-frame checks,
// a reduced-raster PIPE_DELAY=3 instance for fill latency, and a default-timing instance for hsync placement.
module tb_vga_timing_controller;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = 25;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2, VT = 11;
    localparam int FRAME = HT * VT;   // 275

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetN;
    logic [7:0] pix_a, pix_c, pix_d;

    logic [10:0] ax, ay, cx, cy, dx, dy;
    logic        a_fs, a_hs, a_vs, a_act, c_fs, c_hs, c_vs, c_act, d_fs, d_hs, d_vs, d_act;
    logic [3:0]  a_r, a_g, a_b, c_r, c_g, c_b, d_r, d_g, d_b;

    vga_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DELAY(1), .MASK_VALUE(8'h62)
    ) dut_a (
        .clk(clk), .resetN(resetN), .pixel_color_in(pix_a),
        .requested_x(ax), .requested_y(ay), .frame_start(a_fs),
        .vga_hs(a_hs), .vga_vs(a_vs), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
        .active_video(a_act)
    );

    vga_timing_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIPE_DELAY(3), .MASK_VALUE(8'h62)
    ) dut_c (
        .clk(clk), .resetN(resetN), .pixel_color_in(pix_c),
        .requested_x(cx), .requested_y(cy), .frame_start(c_fs),
        .vga_hs(c_hs), .vga_vs(c_vs), .vga_r(c_r), .vga_g(c_g), .vga_b(c_b),
        .active_video(c_act)
    );

    vga_timing_controller dut_d (
        .clk(clk), .resetN(resetN), .pixel_color_in(pix_d),
        .requested_x(dx), .requested_y(dy), .frame_start(d_fs),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .active_video(d_act)
    );

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    int seq_err, hmax, vmax, fs_cnt, fs1, fs2, first_act, act_win;
    int fff_cnt, fff1, fff2, first_hs, hs_win, first_vs, vs_win;
    int first_act_c, r_c_first, first_hs_d, hs_d_win;
    int nz, act_cnt, bad, red, bba, found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: the upstream model answers the request seen before the edge (PIPE_DELAY=1)
    task automatic step();
        logic [10:0] px, py;
        px = ax;
        py = ay;
        @(posedge clk);
        #1;
        case (mode)
            0:       pix_a = (px == 11'd0 && py == 11'd0) ? 8'hFF : 8'h00;
            1:       pix_a = 8'h62;
            2:       pix_a = 8'hE0;
            default: pix_a = 8'hB6;
        endcase
        @(negedge clk);
    endtask

    initial begin
        resetN = 1'b0;
        pix_a  = 8'h00;
        pix_c  = 8'hE0;
        pix_d  = 8'h00;
        seq_err = 0; hmax = 0; vmax = 0; fs_cnt = 0; fs1 = -1; fs2 = -1;
        first_act = -1; act_win = 0; fff_cnt = 0; fff1 = -1; fff2 = -1;
        first_hs = -1; hs_win = 0; first_vs = -1; vs_win = 0;
        first_act_c = -1; r_c_first = -1; first_hs_d = -1; hs_d_win = 0;

        repeat (3) @(negedge clk);
        check("rst_x", ax, 0);
        check("rst_y", ay, 0);
        check("rst_fs", a_fs, 0);
        check("rst_hs_vs", {a_hs, a_vs}, 2'b11);
        check("rst_act", a_act, 0);
        check("rst_rgb", {a_r, a_g, a_b}, 12'h000);
        check("rst_act_pd3", c_act, 0);

        // release between edges; k counts rising edges since release
        resetN = 1'b1;
        check("rel_x0", ax, 0);
        for (int k = 1; k <= 900; k++) begin
            step();
            if (ax != 11'(k % HT) || ay != 11'((k / HT) % VT)) seq_err++;
            if (int'(ax) > hmax) hmax = int'(ax);
            if (int'(ay) > vmax) vmax = int'(ay);
            if (a_fs) begin
                fs_cnt++;
                if (fs_cnt == 1) fs1 = k;
                if (fs_cnt == 2) fs2 = k;
            end
            if (a_act && first_act < 0) first_act = k;
            if (a_act && k <= FRAME) act_win++;
            if ({a_r, a_g, a_b} == 12'hFFF) begin
                fff_cnt++;
                if (fff_cnt == 1) fff1 = k;
                if (fff_cnt == 2) fff2 = k;
            end
            if (!a_hs && first_hs < 0) first_hs = k;
            if (!a_hs && k <= FRAME) hs_win++;
            if (!a_vs && first_vs < 0) first_vs = k;
            if (!a_vs && k <= FRAME) vs_win++;
            if (c_act && first_act_c < 0) begin
                first_act_c = k;
                r_c_first   = int'(c_r);
            end
            if (!d_hs && first_hs_d < 0) first_hs_d = k;
            if (!d_hs && k <= 800) hs_d_win++;
        end
        check("seq_gapless", seq_err, 0);
        check("h_max", hmax, 24);
        check("v_max", vmax, 10);
        check("fs_count", fs_cnt, 3);
        check("fs_first", fs1, 150);
        check("fs_second", fs2, 425);
        check("act_first", first_act, 2);
        check("act_per_frame", act_win, 96);
        check("fff_count", fff_cnt, 4);
        check("fff_first", fff1, 2);
        check("fff_second", fff2, 277);
        check("hs_first", first_hs, 20);
        check("hs_per_frame", hs_win, 44);
        check("vs_first", first_vs, 177);
        check("vs_per_frame", vs_win, 50);
        check("pd3_act_first", first_act_c, 4);
        check("pd3_r_first", r_c_first, 15);
        check("def_hs_first", first_hs_d, 658);
        check("def_hs_len", hs_d_win, 96);

        // transparent colour: black everywhere
        mode = 1; nz = 0; act_cnt = 0;
        repeat (3) step();
        for (int k = 0; k < FRAME; k++) begin
            step();
            if ({a_r, a_g, a_b} != 12'h000) nz++;
            if (a_act) act_cnt++;
        end
        check("mask_black", nz, 0);
        check("mask_act_cnt", act_cnt, 96);

        // pure red: F00 while visible, black in blanking
        mode = 2; bad = 0; red = 0;
        repeat (3) step();
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (a_act) begin
                if ({a_r, a_g, a_b} == 12'hF00) red++;
                else bad++;
            end else if ({a_r, a_g, a_b} != 12'h000) bad++;
        end
        check("red_bad", bad, 0);
        check("red_cnt", red, 96);

        // B6 = 101_101_10 -> B, B, A
        mode = 3; bba = 0;
        repeat (3) step();
        for (int k = 0; k < FRAME; k++) begin
            step();
            if (a_act && {a_r, a_g, a_b} == 12'hBBA) bba++;
        end
        check("expand_cnt", bba, 96);

        // mid-frame reset while hsync is low
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            step();
            if (ax == 11'd20 && ay == 11'd2) found = 1;
        end
        check("mid_reached", found, 1);
        check("mid_hs_before", a_hs, 0);
        #2;
        resetN = 1'b0;
        #1;
        check("mid_async_xy", {ax, ay}, 22'd0);
        check("mid_async_sync", {a_hs, a_vs, a_fs, a_act}, 4'b1100);
        check("mid_async_rgb", {a_r, a_g, a_b}, 12'h000);
        repeat (3) step();
        check("mid_hold_x", ax, 0);
        check("mid_hold_hs", a_hs, 1);
        resetN = 1'b1;
        step();
        check("post_x1", ax, 1);
        check("post_y0", ay, 0);
        check("post_act_k1", a_act, 0);
        step();
        check("post_act_k2", a_act, 1);
        check("post_rgb_k2", {a_r, a_g, a_b}, 12'hBBA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
